debug_reg_dumper: RTL
=====================

Name: debug_reg_dumper

Overview:
- Host-side reader for the processor's register debug port.
- Drives the register select and samples the register value returned for each index.
- Sweeps registers 0..NUM_REGS-1 on a start pulse and emits each 32-bit value as 4 bytes, LSB first, over a valid/ready byte stream.
- Sits beside the pipelined computer top and feeds a UART transmitter or a test bench sink.

Parameters:
- NUM_REGS, 16, registers dumped per sweep (1..16).
- SEL_W, 4, width of the register select.
- DATA_W, 32, width of the debug register value; fixed at 32 (4 bytes).
- SETTLE, 1, cycles to wait after changing the select before capture (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
- debug_reg_select  output  SEL_W  register index presented to the processor debug port.
- debug_reg_out  input  DATA_W  register value returned by the processor for the current select.
- pc_fetch  input  32  processor fetch PC; used only with DUMP_PC_EN.
- byte_data  output  8  stream byte.
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse after the last byte of a sweep is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; debug_reg_select=0; byte_data=0; byte_valid=0; busy=0; done=0.
  - Register index counter, byte counter, settle counter and shift register all cleared.
- States: IDLE, SETTLE, CAPTURE, SEND, DONE.
- IDLE:
  - start=1 -> index=0, debug_reg_select=0, settle counter loaded with SETTLE-1, next state SETTLE.
  - busy rises the cycle after start is seen.
- SETTLE: count down; when the counter reaches 0 -> CAPTURE.
- CAPTURE:
  - Load the shift register with debug_reg_out; byte counter=0.
  - byte_valid=1 from the next cycle; byte_data = shift[7:0]; next state SEND.
- SEND:
  - byte_data and byte_valid are held stable while byte_valid=1 and byte_ready=0.
  - A transfer occurs on byte_valid & byte_ready.
  - On transfer, if byte counter<3: shift right by 8 and increment the counter. byte_valid stays 1 and the next byte is presented the following cycle, giving 1 byte/cycle with byte_ready held high.
  - On transfer of byte 3:
    - If index<NUM_REGS-1: increment index and debug_reg_select, reload the settle counter, byte_valid=0, go to SETTLE.
    - Otherwise go to DONE with byte_valid=0.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: start to first byte_valid = 1 + SETTLE + 1 cycles.
- Per-register overhead between bursts = SETTLE + 1 cycles with byte_valid low.
- start while busy (any state other than IDLE) is ignored; no queueing.
- byte_ready held low indefinitely stalls the sweep with no loss or duplication; debug_reg_select is frozen.
- byte_ready asserted while byte_valid=0 has no effect.
- NUM_REGS=1: single register, DONE follows its 4th byte.
- Index does not wrap within a sweep. debug_reg_select is returned to 0 on entry to DONE.
- Reset mid-sweep aborts immediately: byte_valid drops asynchronously, no done pulse, the next start begins from register 0.
- Captured value is debug_reg_out as sampled in CAPTURE. Later changes to the register file do not alter bytes already captured.

Optional Feature:
- Macro: DEBUG_DUMP_PC_EN.
- When defined:
  - pc_fetch is sampled into a 32-bit holding register in the cycle start is accepted.
  - After the last register's 4th byte, the block enters CAPTURE with the PC holding register as source instead of DONE.
  - It emits 4 more bytes LSB first, then enters DONE.
  - Total sweep = 4*(NUM_REGS+1) bytes; no SETTLE before the PC word.
- When undefined:
  - pc_fetch is unused; total sweep = 4*NUM_REGS bytes.

Test Plan:
- Regs r0..r15 = 0x11110000+i, byte_ready=1, pulse start -> 64 bytes. First four are 00,00,11,11, last four are 0F,00,11,11. debug_reg_select steps 0..15. done pulses once, 1 cycle after the 64th transfer.
- r3=0xDEADBEEF, byte_ready toggled 1/0 every cycle -> bytes EF,BE,AD,DE for r3. byte_data is held stable during every ready=0 cycle, with no duplicates.
- Second start pulse during a sweep (at byte 10) -> ignored. Exactly 64 bytes and one done pulse are produced.
- Assert reset=0 at byte 20 for 2 cycles -> byte_valid=0, busy=0 and debug_reg_select=0 immediately, no done. A new start yields a full 64-byte sweep from r0.
- NUM_REGS=1, SETTLE=3, r0=0x01020304 -> first byte_valid 5 cycles after start. Bytes 04,03,02,01, then done.
- DEBUG_DUMP_PC_EN defined, pc_fetch=0x00000040 at start (pc_fetch then changes) -> 68 bytes, last four 40,00,00,00.

Source files
------------

// File: rtl/debug_reg_dumper.sv
// Purpose: walks the processor debug register port and streams every register as 4 bytes, LSB first.
// Latency: first byte is valid 1+SETTLE+1 cycles after start; each later register adds SETTLE+1 idle cycles.
// Backpressure: byte_valid/byte_ready handshake; byte_ready low freezes data, select and sweep with no loss.
// Optional: define DEBUG_DUMP_PC_EN to append the fetch PC (sampled at start) as a final 4-byte word.
module debug_reg_dumper #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int DATA_W   = 32,
  parameter int SETTLE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [SEL_W-1:0]  debug_reg_select,
  input  logic [DATA_W-1:0] debug_reg_out,
  input  logic [31:0]       pc_fetch,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [SEL_W-1:0]  regIdx;
  logic [CNT_W-1:0]  settleCnt;
  logic [1:0]        byteCnt;
  logic [DATA_W-1:0] shiftReg;
  logic [DATA_W-1:0] captureSrc;
  logic              lastByte;
  logic              lastReg;
  logic              pcPending;

  assign lastByte         = (byteCnt == 2'd3);
  assign lastReg          = (regIdx == LAST_IDX);
  assign debug_reg_select = regIdx;
  assign byte_data        = shiftReg[7:0];

`ifdef DEBUG_DUMP_PC_EN
  logic [31:0] pcHold;
  logic        pcPhase;

  // PC is latched when the sweep is accepted; pcPhase marks that the trailing PC word is being sent
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcHold  <= '0;
      pcPhase <= 1'b0;
    end else if (state == S_IDLE && start) begin
      pcHold  <= pc_fetch;
      pcPhase <= 1'b0;
    end else if (state == S_SEND && byte_ready && lastByte && lastReg && !pcPhase) begin
      pcPhase <= 1'b1;
    end
  end

  assign pcPending  = !pcPhase;
  assign captureSrc = pcPhase ? pcHold : debug_reg_out;
`else
  logic unusedPc;

  assign unusedPc   = ^pc_fetch;
  assign pcPending  = 1'b0;
  assign captureSrc = debug_reg_out;
`endif

  // State register; reset drops byte_valid and busy immediately because both decode from state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    nextState  = state;
    byte_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nextState = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settleCnt == '0) begin
          nextState = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy      = 1'b1;
        nextState = S_SEND;
      end
      S_SEND: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        if (byte_ready && lastByte) begin
          if (!lastReg) begin
            nextState = S_SETTLE;
          end else if (pcPending) begin
            // PC word needs no settle time: it comes from our own holding register
            nextState = S_CAPTURE;
          end else begin
            nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Datapath: register index, settle countdown, byte counter and the shifting capture register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regIdx    <= '0;
      settleCnt <= '0;
      byteCnt   <= '0;
      shiftReg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            regIdx    <= '0;
            settleCnt <= SETTLE_INIT;
          end
        end
        S_SETTLE: begin
          if (settleCnt != '0) begin
            settleCnt <= settleCnt - CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          shiftReg <= captureSrc;
          byteCnt  <= '0;
        end
        S_SEND: begin
          if (byte_ready) begin
            if (!lastByte) begin
              shiftReg <= shiftReg >> 8;
              byteCnt  <= byteCnt + 2'd1;
            end else if (!lastReg) begin
              regIdx    <= regIdx + SEL_W'(1);
              settleCnt <= SETTLE_INIT;
            end else if (!pcPending) begin
              // Sweep is over: park the select back at register 0
              regIdx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
